adder_axi_sequencer: RTL and testbench
======================================

Name: adder_axi_sequencer

Overview:
- AXI-Lite master that sequences the memory-mapped adder slave on behalf of two requesters.
- Round-robin arbitration grants one requester at a time.
- Granted operands are written to adder offsets 0x0 and 0x4; sum and carry are then read from 0x8 and 0xC.
- Result is returned on a shared response port tagged with the requester id.
- Sits between client logic and the adder; it is the only master on the adder's s1 port.

Parameters:
DATA_WIDTH, 32, operand/result and AXI data width
ADDR_WIDTH, 8, AXI address width
BASE_ADDR, 0, adder base address added to all offsets
TIMEOUT_CYCLES, 255, watchdog limit (used only with SEQ_TIMEOUT_EN)

Ports:
m1_axi_aclk  in  1  clock
m1_axi_areset  in  1  reset, asynchronous, active-high
req0_valid / req1_valid  in  1  requester operand pair valid
req0_ready / req1_ready  out  1  requester accepted (one-cycle pulse)
req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed
rsp_id  out  1  requester index (0/1)
rsp_sum  out  DATA_WIDTH  value read at 0x8
rsp_carry  out  DATA_WIDTH  value read at 0xC
rsp_err  out  1  slave error or timeout
m1_axi_awaddr  out  ADDR_WIDTH  write address
m1_axi_awvalid  out  1  write address valid
m1_axi_awready  in  1  write address ready
m1_axi_wdata  out  DATA_WIDTH  write data
m1_axi_wstrb  out  DATA_WIDTH/8  write strobes, always all ones
m1_axi_wvalid  out  1  write data valid
m1_axi_wready  in  1  write data ready
m1_axi_bresp  in  1  write response, 1 = error
m1_axi_bvalid  in  1  write response valid
m1_axi_bready  out  1  write response ready
m1_axi_araddr  out  ADDR_WIDTH  read address
m1_axi_arvalid  out  1  read address valid
m1_axi_arready  in  1  read address ready
m1_axi_rdata  in  DATA_WIDTH  read data
m1_axi_rresp  in  1  read response, 1 = error
m1_axi_rvalid  in  1  read data valid
m1_axi_rready  out  1  read data ready

Behaviour:
- Reset (async, immediate):
  - All valid/ready outputs and rsp_err are 0; addresses, data and rsp_* fields are 0.
  - wstrb is all ones.
  - State is IDLE; last_grant = 1, so req0 wins first.
- FSM states: IDLE, WA, BA, WB, BB, ARS, RS, ARC, RC, RESP.
- IDLE:
  - If any reqN_valid, grant round-robin: the requester not granted last wins on a tie; a lone requester wins.
  - Pulse reqN_ready for one cycle, capture a/b/id, go to WA.
  - Only one reqN_ready may be high in any cycle, and only in IDLE.
- WA/WB:
  - Assert awvalid and wvalid with addr BASE+0x0 (data a) or BASE+0x4 (data b).
  - Each valid drops independently on its own handshake.
  - Advance to BA/BB when both handshakes are done, whether in the same or different cycles.
- BA/BB:
  - bready = 1; advance on bvalid.
  - bresp = 1 sets err and jumps to RESP with sum/carry = 0.
- ARS/ARC:
  - arvalid with BASE+0x8 / BASE+0xC; advance on arready.
  - rready is held 0 in these states.
- RS/RC:
  - rready = 1; on rvalid, capture rdata into sum/carry.
  - rresp = 1 aborts to RESP with err set and uncaptured fields = 0.
- RESP:
  - rsp_valid = 1 with fields stable until rsp_ready; then IDLE.
  - A new grant happens no earlier than the cycle after the response is consumed.
- Valids stay asserted until their handshake; address/data stay stable while valid.
- Latency, with a slave that has ready high and returns bvalid/rvalid in the cycle after the address handshake: rsp_valid rises 8 clock edges after the acceptance edge.
- Address arithmetic is BASE_ADDR + offset, truncated to ADDR_WIDTH (wraps).
- Reset mid-transaction:
  - The transaction is dropped and no response is produced.
  - All AXI valids deassert asynchronously.
- Requests arriving while busy are held by the requester (valid stays high); none are lost.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
  - When defined, a counter runs in every non-IDLE, non-RESP state and clears on each state change.
  - When it reaches TIMEOUT_CYCLES, the FSM deasserts all AXI valids/readies, sets rsp_err = 1 with sum/carry = 0, and goes to RESP.
- Without the macro, the FSM waits indefinitely on the slave and no counter logic is present.

Test Plan:
- req0 a=0xAABB, b=0xCCDD, zero-wait adder slave -> writes 0x0=0xAABB and 0x4=0xCCDD, reads 0x8/0xC; rsp_id=0, rsp_sum=0x17798, rsp_carry=0, err=0; rsp_valid 8 edges after accept.
- req0 and req1 valid together, three back-to-back rounds -> grants alternate 0,1,0; each rsp_id matches its grant; never two readies high at once.
- Slave holds awready low 3 cycles while wready is high immediately -> wvalid drops after its handshake, awvalid is held; advance only after both; data correct.
- Slave returns bresp=1 on the 0x4 write -> no reads issued; rsp_err=1, sum=0, carry=0.
- Assert reset during RS with rvalid pending -> all outputs 0 immediately; after release, next req1 completes normally with req1 granted first only if req0 idle.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready stuck 0 -> arvalid drops after 16 cycles in ARS; rsp_err=1; without the macro arvalid is held indefinitely.

Source files
------------

// File: rtl/adder_axi_sequencer.sv
// rtl/adder_axi_sequencer.sv - AXI-Lite master sequencing the adder slave for two round-robin requesters
//
// Purpose:
//   Grants one of two requesters at a time (round robin, req0 first after reset).
//   It writes operand a to BASE+0x0 and operand b to BASE+0x4, then reads sum
//   from BASE+0x8 and carry from BASE+0xC. The result goes back on a shared
//   response port, tagged with the id of the requester.
//
// Ports:
//   m1_axi_aclk, m1_axi_areset        clock, asynchronous active-high reset
//   reqN_valid/ready, reqN_a/b        requester operand handshake (N = 0, 1)
//   rsp_valid/ready, rsp_id/sum/carry/err
//                                     tagged result handshake
//   m1_axi_aw*/w*/b*                  AXI-Lite write address, data and response channels
//   m1_axi_ar*/r*                     AXI-Lite read address and data channels
//
// Configuration:
//   SEQ_TIMEOUT_EN   when defined, a watchdog ends any slave wait after
//                    TIMEOUT_CYCLES cycles. The response then carries rsp_err = 1.

module adder_axi_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      m1_axi_aclk,
    input  logic                      m1_axi_areset,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DATA_WIDTH-1:0]     req0_a,
    input  logic [DATA_WIDTH-1:0]     req0_b,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DATA_WIDTH-1:0]     req1_a,
    input  logic [DATA_WIDTH-1:0]     req1_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [DATA_WIDTH-1:0]     rsp_sum,
    output logic [DATA_WIDTH-1:0]     rsp_carry,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
    output logic                      m1_axi_awvalid,
    input  logic                      m1_axi_awready,
    output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
    output logic                      m1_axi_wvalid,
    input  logic                      m1_axi_wready,
    input  logic                      m1_axi_bresp,
    input  logic                      m1_axi_bvalid,
    output logic                      m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
    output logic                      m1_axi_arvalid,
    input  logic                      m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
    input  logic                      m1_axi_rresp,
    input  logic                      m1_axi_rvalid,
    output logic                      m1_axi_rready
);

    // Register addresses wrap within ADDR_WIDTH.
    localparam logic [ADDR_WIDTH-1:0] ADDR_A     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B     = ADDR_WIDTH'(BASE_ADDR + 4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SUM   = ADDR_WIDTH'(BASE_ADDR + 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CARRY = ADDR_WIDTH'(BASE_ADDR + 12);

    typedef enum logic [3:0] {
        IDLE, WA, BA, WB, BB, ARS, RS, ARC, RC, RESP
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  last_grant;
    logic [DATA_WIDTH-1:0] cur_a;
    logic [DATA_WIDTH-1:0] cur_b;
    // Records address/data handshakes already done in WA/WB, because the slave may accept them in different cycles.
    logic                  aw_done;
    logic                  w_done;

    logic                  grant_en;
    logic                  grant_id;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  err_event;
    logic                  clr_result;
    logic                  cap_sum;
    logic                  cap_carry;
    logic                  timeout_hit;

    assign m1_axi_wstrb = '1;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Fires in the last allowed cycle. A stuck valid is then high for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            wd_cnt <= '0;
        end else if (state_next != state || state == IDLE || state == RESP) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_en       = 1'b0;
        grant_id       = 1'b0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        err_event      = 1'b0;
        clr_result     = 1'b0;
        cap_sum        = 1'b0;
        cap_carry      = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        rsp_valid      = 1'b0;
        m1_axi_awaddr  = '0;
        m1_axi_awvalid = 1'b0;
        m1_axi_wdata   = '0;
        m1_axi_wvalid  = 1'b0;
        m1_axi_bready  = 1'b0;
        m1_axi_araddr  = '0;
        m1_axi_arvalid = 1'b0;
        m1_axi_rready  = 1'b0;

        case (state)
            IDLE: begin
                // No grant during reset. State already holds IDLE while reset is high, so the requester handshake is gated here.
                if (!m1_axi_areset && (req0_valid || req1_valid)) begin
                    grant_en   = 1'b1;
                    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = WA;
                end
            end
            WA, WB: begin
                m1_axi_awvalid = ~aw_done;
                m1_axi_wvalid  = ~w_done;
                m1_axi_awaddr  = (state == WA) ? ADDR_A : ADDR_B;
                m1_axi_wdata   = (state == WA) ? cur_a : cur_b;
                aw_hs          = m1_axi_awvalid & m1_axi_awready;
                w_hs           = m1_axi_wvalid & m1_axi_wready;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = (state == WA) ? BA : BB;
                end
            end
            BA, BB: begin
                m1_axi_bready = 1'b1;
                if (m1_axi_bvalid) begin
                    if (m1_axi_bresp) begin
                        err_event  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = (state == BA) ? WB : ARS;
                    end
                end
            end
            ARS, ARC: begin
                m1_axi_arvalid = 1'b1;
                m1_axi_araddr  = (state == ARS) ? ADDR_SUM : ADDR_CARRY;
                if (m1_axi_arready) begin
                    state_next = (state == ARS) ? RS : RC;
                end
            end
            RS, RC: begin
                m1_axi_rready = 1'b1;
                if (m1_axi_rvalid) begin
                    if (m1_axi_rresp) begin
                        err_event  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cap_sum    = (state == RS);
                        cap_carry  = (state == RC);
                        state_next = (state == RS) ? ARC : RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The watchdog only ends a wait with no progress. A handshake in the same cycle wins, so no accepted transfer is orphaned.
        if (timeout_hit && state_next == state && state != IDLE && state != RESP) begin
            state_next = RESP;
            err_event  = 1'b1;
            clr_result = 1'b1;
        end
    end

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            last_grant <= 1'b1;
            cur_a      <= '0;
            cur_b      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_carry  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (grant_en) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                cur_a      <= grant_id ? req1_a : req0_a;
                cur_b      <= grant_id ? req1_b : req0_b;
                rsp_sum    <= '0;
                rsp_carry  <= '0;
                rsp_err    <= 1'b0;
            end

            if (state_next != state) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done <= 1'b1;
                end
                if (w_hs) begin
                    w_done <= 1'b1;
                end
            end

            if (cap_sum) begin
                rsp_sum <= m1_axi_rdata;
            end
            if (cap_carry) begin
                rsp_carry <= m1_axi_rdata;
            end
            if (err_event) begin
                rsp_err <= 1'b1;
            end
            if (clr_result) begin
                rsp_sum   <= '0;
                rsp_carry <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adder_axi_sequencer.sv
// tb/tb_adder_axi_sequencer.sv - directed self-checking bench for adder_axi_sequencer with a behavioural adder slave

module tb_adder_axi_sequencer;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_sum, rsp_carry;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rresp, rvalid, rready;

    int checks = 0;
    int errors = 0;

    adder_axi_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .m1_axi_aclk(clk), .m1_axi_areset(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
        .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
        .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    // Behavioural adder slave. Readies change only at negedge. A handshake
    // predicted at one negedge takes effect at the next posedge. It is applied
    // at the following negedge.
    logic [31:0] mem_a, mem_b, q_wdata, wr_data;
    logic [7:0]  q_awaddr, q_araddr, wr_addr;
    logic        p_aw, p_w, p_b, p_ar, p_r, have_aw, have_w;
    logic [32:0] sum33;
    int          aw_stall = 0;
    int          rd_count = 0;
    bit          b_err4   = 1'b0;
    bit          ar_stuck = 1'b0;

    initial begin : slave
        mem_a = '0; mem_b = '0; q_wdata = '0; wr_data = '0;
        q_awaddr = '0; q_araddr = '0; wr_addr = '0; sum33 = '0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; have_aw = 0; have_w = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rresp = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; have_aw = 0; have_w = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
                rvalid = 0; rresp = 0; rdata = '0;
            end else begin
                if (p_b) bvalid = 0;
                if (p_r) rvalid = 0;
                if (p_aw) begin wr_addr = q_awaddr; have_aw = 1; end
                if (p_w) begin wr_data = q_wdata; have_w = 1; end
                if (have_aw && have_w) begin
                    have_aw = 0; have_w = 0;
                    if (wr_addr == 8'h04 && b_err4) begin
                        bresp = 1;
                    end else begin
                        bresp = 0;
                        if (wr_addr == 8'h00) mem_a = wr_data;
                        else if (wr_addr == 8'h04) mem_b = wr_data;
                    end
                    bvalid = 1;
                end
                if (p_ar) begin
                    rd_count++;
                    sum33  = {1'b0, mem_a} + {1'b0, mem_b};
                    rresp  = 0;
                    rvalid = 1;
                    if (q_araddr == 8'h08) rdata = sum33[31:0];
                    else if (q_araddr == 8'h0C) rdata = {31'b0, sum33[32]};
                    else rdata = '0;
                end
                awready = (aw_stall == 0);
                if (awvalid && aw_stall > 0) aw_stall--;
                wready  = 1;
                arready = !ar_stuck;
                p_aw = awvalid && awready;
                if (p_aw) q_awaddr = awaddr;
                p_w = wvalid && wready;
                if (p_w) q_wdata = wdata;
                p_b = bvalid && bready;
                p_ar = arvalid && arready;
                if (p_ar) q_araddr = araddr;
                p_r = rvalid && rready;
            end
        end
    end

    always @(negedge clk) begin
        assert (!(req0_ready && req1_ready)) else begin
            errors++;
            $error("FAIL ready_onehot observed=%0b%0b expected=at most one", req0_ready, req1_ready);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic id, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            #1;
            got = id ? req1_ready : req0_ready;
            if (got) break;
            @(posedge clk);
        end
        chk("req_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (rsp_valid) break;
        end
        chk("rsp_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int edges;
    int hi;

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'hF);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic transaction and latency
        rd_count = 0;
        do_req(1'b0, 32'h0000AABB, 32'h0000CCDD);
        wait_rsp(edges);
        chk("t1_latency", 64'(edges), 64'd8);
        chk("t1_id", 64'(rsp_id), 64'd0);
        chk("t1_sum", 64'(rsp_sum), 64'h17798);
        chk("t1_carry", 64'(rsp_carry), 64'd0);
        chk("t1_err", 64'(rsp_err), 64'd0);
        chk("t1_mem_a", 64'(mem_a), 64'hAABB);
        chk("t1_mem_b", 64'(mem_b), 64'hCCDD);
        chk("t1_reads", 64'(rd_count), 64'd2);
        consume();
        chk("t1_rsp_drop", 64'(rsp_valid), 64'd0);

        // Carry out of the top bit, lone req1
        do_req(1'b1, 32'hFFFFFFFF, 32'h00000002);
        wait_rsp(edges);
        chk("t2_id", 64'(rsp_id), 64'd1);
        chk("t2_sum", 64'(rsp_sum), 64'd1);
        chk("t2_carry", 64'(rsp_carry), 64'd1);
        consume();

        // Round robin with both requesters held valid
        req0_a = 32'd5; req0_b = 32'd7; req1_a = 32'h100; req1_b = 32'h23;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 50; i++) begin
                #1;
                if (req0_ready || req1_ready) break;
                @(posedge clk);
            end
            chk("rr_onehot", 64'(req0_ready && req1_ready), 64'd0);
            chk("rr_grant1", 64'(req1_ready), 64'(r % 2));
            chk("rr_grant0", 64'(req0_ready), 64'((r + 1) % 2));
            if (r == 2) begin
                @(posedge clk);
                #1;
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            wait_rsp(edges);
            chk("rr_no_grant_in_resp", 64'(req0_ready || req1_ready), 64'd0);
            chk("rr_id", 64'(rsp_id), 64'(r % 2));
            chk("rr_sum", 64'(rsp_sum), (r % 2 == 1) ? 64'h123 : 64'd12);
            consume();
        end

        // awready stalled 3 cycles, wready immediate
        aw_stall = 3;
        do_req(1'b0, 32'h12345678, 32'h11111111);
        chk("st_c1_awvalid", 64'(awvalid), 64'd1);
        chk("st_c1_wvalid", 64'(wvalid), 64'd1);
        chk("st_c1_awaddr", 64'(awaddr), 64'h00);
        @(posedge clk); #1;
        chk("st_c2_wvalid", 64'(wvalid), 64'd0);
        chk("st_c2_awvalid", 64'(awvalid), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("st_c4_awvalid", 64'(awvalid), 64'd1);
        @(posedge clk); #1;
        chk("st_c5_awvalid", 64'(awvalid), 64'd0);
        chk("st_c5_bready", 64'(bready), 64'd1);
        wait_rsp(edges);
        chk("st_sum", 64'(rsp_sum), 64'h23456789);
        chk("st_err", 64'(rsp_err), 64'd0);
        consume();

        // Write error on the 0x4 write
        b_err4 = 1'b1;
        rd_count = 0;
        do_req(1'b1, 32'd1, 32'd2);
        wait_rsp(edges);
        chk("be_err", 64'(rsp_err), 64'd1);
        chk("be_sum", 64'(rsp_sum), 64'd0);
        chk("be_carry", 64'(rsp_carry), 64'd0);
        chk("be_reads", 64'(rd_count), 64'd0);
        consume();
        b_err4 = 1'b0;

        // Reset while in RS with rvalid pending
        do_req(1'b0, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        chk("mr_pre_rready", 64'(rready), 64'd1);
        chk("mr_pre_rvalid", 64'(rvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_rready", 64'(rready), 64'd0);
        chk("mr_arvalid", 64'(arvalid), 64'd0);
        chk("mr_awvalid", 64'(awvalid), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_rsp_sum", 64'(rsp_sum), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_idle_rsp", 64'(rsp_valid), 64'd0);
        do_req(1'b1, 32'h40, 32'h02);
        wait_rsp(edges);
        chk("mr_id", 64'(rsp_id), 64'd1);
        chk("mr_sum", 64'(rsp_sum), 64'h42);
        chk("mr_err", 64'(rsp_err), 64'd0);
        consume();

        // arready stuck low
        ar_stuck = 1'b1;
        do_req(1'b0, 32'd9, 32'd10);
        for (int i = 0; i < 20; i++) begin
            if (arvalid) break;
            @(posedge clk); #1;
        end
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            if (!arvalid) break;
            hi++;
            @(posedge clk); #1;
        end
`ifdef SEQ_TIMEOUT_EN
        chk("to_ar_cycles", 64'(hi), 64'd16);
        ar_stuck = 1'b0;
        wait_rsp(edges);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_sum", 64'(rsp_sum), 64'd0);
        chk("to_carry", 64'(rsp_carry), 64'd0);
`else
        chk("hold_ar_cycles", 64'(hi), 64'd60);
        chk("hold_no_rsp", 64'(rsp_valid), 64'd0);
        ar_stuck = 1'b0;
        wait_rsp(edges);
        chk("hold_err", 64'(rsp_err), 64'd0);
        chk("hold_sum", 64'(rsp_sum), 64'd19);
`endif
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
